// File: rtl/rv_if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// A one-entry skid buffer holds a word that returns while the stage is stalled.
module rv_if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_write_i,
  input  logic        IF_ID_write_i,
  input  logic        IF_flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_en_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] ID_pc_o,
  output logic [31:0] ID_instr_o,
  output logic        ID_valid_o
);

  logic [31:0] pc_q, pc_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;

  logic        avail;
  logic        adv;
  logic [31:0] cur_instr;
  logic [31:0] next_pc;
  logic        fetch_en;

  // The buffered word is always older than anything on the memory bus.
  assign avail     = buf_valid_q | rsp_valid_q;
  assign cur_instr = buf_valid_q ? buf_instr_q : imem_rdata_i;
  assign adv       = PC_write_i & IF_ID_write_i & avail & ~IF_flush_i;
  assign next_pc   = IF_flush_i ? branch_target_i : (adv ? pc_q + 32'd4 : pc_q);
  assign fetch_en  = IF_flush_i | adv | ~avail;

  assign imem_en_o   = fetch_en;
  assign imem_addr_o = next_pc;
  assign ID_pc_o     = id_pc_q;
  assign ID_instr_o  = id_instr_q;
  assign ID_valid_o  = id_valid_q;

  always_comb begin
    pc_d        = next_pc;
    rsp_valid_d = rsp_valid_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    id_pc_d     = id_pc_q;
    id_instr_d  = id_instr_q;
    id_valid_d  = id_valid_q;

    if (IF_flush_i) begin
      rsp_valid_d = 1'b1;
      buf_valid_d = 1'b0;
      id_instr_d  = NOP_INSTR;
      id_valid_d  = 1'b0;
    end else if (adv) begin
      rsp_valid_d = 1'b1;
      buf_valid_d = 1'b0;
      id_pc_d     = pc_q;
      id_instr_d  = cur_instr;
      id_valid_d  = 1'b1;
    end else begin
      rsp_valid_d = fetch_en;
      if (rsp_valid_q && !buf_valid_q) begin
        buf_instr_d = imem_rdata_i;
        buf_valid_d = 1'b1;
      end
      // Nothing to hand over yet, so ID sees a bubble rather than a stale word.
      if (IF_ID_write_i && !avail) begin
        id_pc_d    = pc_q;
        id_instr_d = NOP_INSTR;
        id_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      rsp_valid_q <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= '0;
      id_pc_q     <= RESET_PC;
      id_instr_q  <= NOP_INSTR;
      id_valid_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      rsp_valid_q <= rsp_valid_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      id_pc_q     <= id_pc_d;
      id_instr_q  <= id_instr_d;
      id_valid_q  <= id_valid_d;
    end
  end

endmodule

// File: tb/tb_rv_if_stage.sv
// Self-checking bench for rv_if_stage: directed hazard scenarios followed by random
// stall/flush traffic, compared against an instruction-stream model.
module tb_rv_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcWrite, idWrite, flush;
  logic [31:0] target;
  logic        imemEn;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata;
  logic [31:0] idPc, idInstr;
  logic        idValid;

  int compared   = 0;
  int mismatched = 0;

  // Model: the stream delivers the word at mPc once a word is in hand (mReady).
  logic [31:0] mPc, mIdPc, mIdInstr;
  logic        mReady, mIdValid;

  always #5 clk = ~clk;

  rv_if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .PC_write_i(pcWrite), .IF_ID_write_i(idWrite),
    .IF_flush_i(flush), .branch_target_i(target),
    .imem_en_o(imemEn), .imem_addr_o(imemAddr), .imem_rdata_i(imemRdata),
    .ID_pc_o(idPc), .ID_instr_o(idInstr), .ID_valid_o(idValid)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a >> 2) * 32'h100;
  endfunction

  // Synchronous memory; garbage on the bus whenever no read was issued.
  always @(posedge clk) imemRdata <= imemEn ? memWord(imemAddr) : $urandom();

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic p, input logic i, input logic f, input logic [31:0] t);
    pcWrite = p;
    idWrite = i;
    flush   = f;
    target  = t;
  endtask

  task automatic resetModel();
    mPc      = RESET_PC;
    mReady   = 1'b0;
    mIdPc    = RESET_PC;
    mIdInstr = NOP;
    mIdValid = 1'b0;
  endtask

  task automatic checkOutput();
    logic consume, expEn;
    logic [31:0] expAddr;
    consume = mReady & pcWrite & idWrite & ~flush;
    expEn   = flush | consume | ~mReady;
    expAddr = flush ? target : (consume ? mPc + 32'd4 : mPc);
    cmp("idPc", idPc, mIdPc);
    cmp("idInstr", idInstr, mIdInstr);
    cmp("idValid", {31'b0, idValid}, {31'b0, mIdValid});
    cmp("imemEn", {31'b0, imemEn}, {31'b0, expEn});
    if (expEn) cmp("imemAddr", imemAddr, expAddr);
  endtask

  task automatic updateModel();
    if (flush) begin
      mPc      = target;
      mIdInstr = NOP;
      mIdValid = 1'b0;
    end else if (mReady && pcWrite && idWrite) begin
      mIdPc    = mPc;
      mIdInstr = memWord(mPc);
      mIdValid = 1'b1;
      mPc      = mPc + 32'd4;
    end else if (idWrite && !mReady) begin
      mIdPc    = mPc;
      mIdInstr = NOP;
      mIdValid = 1'b0;
    end
    mReady = 1'b1;
  endtask

  task automatic step(input logic p, input logic i, input logic f, input logic [31:0] t);
    applyStimulus(p, i, f, t);
    #1;
    checkOutput();
    updateModel();
    @(negedge clk);
  endtask

  task automatic expectId(input logic [31:0] pc, input logic [31:0] instr, input logic v);
    cmp("dirPc", idPc, pc);
    cmp("dirInstr", idInstr, instr);
    cmp("dirValid", {31'b0, idValid}, {31'b0, v});
  endtask

  task automatic checkReset();
    expectId(RESET_PC, NOP, 1'b0);
    cmp("rstEn", {31'b0, imemEn}, 32'd1);
    cmp("rstAddr", imemAddr, RESET_PC);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    checkReset();
    resetModel();
    rst = 1'b0;

    // Straight-line fetch until ID holds 0x8, then a three-cycle load-use stall.
    repeat (4) step(1, 1, 0, 0);
    expectId(32'h8, memWord(32'h8), 1'b1);
    repeat (3) step(0, 0, 0, 0);
    expectId(32'h8, memWord(32'h8), 1'b1);
    step(1, 1, 0, 0);
    expectId(32'hC, memWord(32'hC), 1'b1);
    step(1, 1, 0, 0);
    expectId(32'h10, memWord(32'h10), 1'b1);

    // Plain redirect.
    step(1, 1, 1, 32'h40);
    expectId(32'h10, NOP, 1'b0);
    step(1, 1, 0, 0);
    expectId(32'h40, memWord(32'h40), 1'b1);

    // Flush arriving while stalled with a word sitting in the buffer.
    repeat (2) step(1, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h80);
    step(1, 1, 0, 0);
    expectId(32'h80, memWord(32'h80), 1'b1);

    // Mixed enables behave as stalls.
    repeat (2) step(1, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0);
    repeat (2) step(1, 1, 0, 0);

    // PC wrap-around.
    step(1, 1, 1, 32'hFFFF_FFFC);
    step(1, 1, 0, 0);
    expectId(32'hFFFF_FFFC, memWord(32'hFFFF_FFFC), 1'b1);
    step(1, 1, 0, 0);
    expectId(32'h0, memWord(32'h0), 1'b1);

    // Asynchronous reset mid-stall with the buffer occupied.
    step(1, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    checkReset();
    resetModel();
    repeat (2) @(negedge clk);
    applyStimulus(1, 1, 0, 0);
    rst = 1'b0;
    repeat (3) step(1, 1, 0, 0);
    expectId(32'h4, memWord(32'h4), 1'b1);

    // Random stall / flush traffic.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0, $urandom() & 32'hFFFF_FFFC);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rv_if_stage.md
Name: rv_if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register.
- Consumes the stall and flush controls produced by hazard detection and the branch unit: PC write enable, IF/ID write enable, flush with redirect target.
- Drives a synchronous-read instruction memory with one-cycle read latency.
- Holds any fetched word that returns during a stall in a one-entry skid buffer, so no instruction is lost or duplicated.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, encoding (addi x0,x0,0) inserted into IF/ID on bubble or flush.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- PC_write_i  input  1  0 = stall PC (from hazard detect)
- IF_ID_write_i  input  1  0 = hold IF/ID register (from hazard detect)
- IF_flush_i  input  1  taken branch/jump resolved; squash IF and redirect
- branch_target_i  input  32  redirect PC, sampled when IF_flush_i=1
- imem_en_o  output  1  read strobe to instruction memory
- imem_addr_o  output  32  read address, valid when imem_en_o=1
- imem_rdata_i  input  32  read data, valid only in the cycle after imem_en_o=1
- ID_pc_o  output  32  IF/ID register: PC of instruction
- ID_instr_o  output  32  IF/ID register: instruction
- ID_valid_o  output  1  IF/ID register: 1 = real instruction, 0 = bubble

Behaviour:
- State:
  - pc: PC whose read data is due or buffered.
  - rsp_valid: a read issued last cycle, not squashed.
  - buf_valid / buf_instr: skid buffer.
  - IF/ID register: ID_pc_o, ID_instr_o, ID_valid_o.
- Reset (async, any time, including mid-stall or mid-flush): pc=RESET_PC, rsp_valid=0, buf_valid=0, ID_pc_o=RESET_PC, ID_instr_o=NOP_INSTR, ID_valid_o=0. Outstanding memory data is discarded.
- Combinational terms:
  - avail = buf_valid | rsp_valid.
  - cur_instr = buf_valid ? buf_instr : imem_rdata_i. The buffer always takes priority.
  - adv = PC_write_i & IF_ID_write_i & avail & ~IF_flush_i.
  - next_pc = IF_flush_i ? branch_target_i : adv ? pc+4 : pc. Wrap-around is modulo 2^32 with no trap.
  - imem_en_o = IF_flush_i | adv | ~avail.
  - imem_addr_o = next_pc.
- Sequential (priority in order):
  - IF_flush_i=1:
    - pc<=branch_target_i, rsp_valid<=1, buf_valid<=0.
    - IF/ID <= {branch_target_i-ignored PC, NOP_INSTR, valid 0}. ID_pc_o keeps its value.
    - Flush wins over any stall.
  - adv=1:
    - IF/ID <= {pc, cur_instr, 1}.
    - pc<=pc+4, rsp_valid<=1, buf_valid<=0.
  - Otherwise:
    - rsp_valid<=imem_en_o.
    - If rsp_valid & ~buf_valid: buf_instr<=imem_rdata_i, buf_valid<=1. Buffer captures a word arriving during a stall.
    - IF/ID: if IF_ID_write_i=1 & ~avail, load bubble {pc, NOP_INSTR, 0}. Else hold.
- Mixed enables: PC_write_i=1 with IF_ID_write_i=0, or the reverse, is treated as a stall. PC does not advance unless the instruction is consumed.
- Latency and throughput:
  - First instruction reaches ID two cycles after rst deasserts.
  - Steady-state throughput is one instruction per cycle.
  - Flush penalty is one bubble cycle plus the cycle the flushed instruction occupied.
- Stall-release: the first post-stall instruction comes from the buffer; the next read is issued in that same cycle at pc+4. No duplicate and no skipped PC.
- Never issue a read whose data can be neither consumed nor buffered. A second read during a stall is illegal, because imem_en_o=0 whenever avail=1 and adv=0.

Test Plan:
- Reset release, PC_write_i=IF_ID_write_i=1, mem[n]=n*0x100 → imem_addr_o 0x0,0x4,0x8..., ID_pc_o/ID_instr_o = 0x0/0x000, 0x4/0x100, ... on consecutive cycles from cycle 2; ID_valid_o=1.
- Load-use stall: drop PC_write_i and IF_ID_write_i for 3 cycles while ID holds 0x8 → ID holds 0x8 throughout; imem_en_o=0 after the first stall cycle; after release ID shows 0xC then 0x10, no repeat or skip.
- Flush with IF_flush_i=1, branch_target_i=0x40 → next cycle ID_valid_o=0, ID_instr_o=0x00000013, imem_addr_o=0x40; then ID_pc_o=0x40 with mem[0x40] and valid=1.
- Simultaneous flush and stall (all three asserted) → redirect to target taken, buffer cleared, bubble inserted; the stale buffered word never appears in ID.
- Reset asserted mid-stall with buf_valid=1 → all outputs return to reset values immediately (async); after release, fetch restarts at RESET_PC.
- Wrap-around: branch_target_i=0xFFFFFFFC → ID shows 0xFFFFFFFC, then 0x00000000.
